// File: rtl/tx_axis_arbiter.sv
// Round-robin arbiter that merges N AXI-Stream requesters onto one MAC transmit
// stream, locking the grant for a whole frame and counting completed and aborted frames.
module tx_axis_arbiter #(
  parameter int unsigned N_PORTS   = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_PORTS*32-1:0]        s_axis_tdata,
  input  logic [N_PORTS*4-1:0]         s_axis_tkeep,
  input  logic [N_PORTS-1:0]           s_axis_tvalid,
  input  logic [N_PORTS-1:0]           s_axis_tlast,
  output logic [N_PORTS-1:0]           s_axis_tready,
  output logic [31:0]                  m00_axis_tdata,
  output logic [3:0]                   m00_axis_tkeep,
  output logic                         m00_axis_tvalid,
  output logic                         m00_axis_tlast,
  input  logic                         m00_axis_tready,
  output logic [$clog2(N_PORTS)-1:0]   grant_idx,
  output logic                         busy,
  output logic [CNT_WIDTH-1:0]         frame_count,
  output logic [CNT_WIDTH-1:0]         abort_count
);

  localparam int unsigned GW = $clog2(N_PORTS);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]    state;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] winner;
  logic          found;
  logic          g_valid;
  logic          g_last;

  assign g_valid = s_axis_tvalid[grant_idx];
  assign g_last  = s_axis_tlast[grant_idx];
  assign busy    = (state == LOCKED);

  // Search upward from last_grant+1 with wrap; last_grant itself is visited last.
  always_comb begin
    winner = last_grant;
    found  = 1'b0;
    for (int unsigned k = 1; k <= N_PORTS; k++) begin
      logic [GW-1:0] cand;
      cand = GW'((32'(last_grant) + k) % N_PORTS);
      if (!found && s_axis_tvalid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    m00_axis_tdata  = '0;
    m00_axis_tkeep  = '0;
    m00_axis_tvalid = 1'b0;
    m00_axis_tlast  = 1'b0;
    s_axis_tready   = '0;
    if (state == LOCKED) begin
      m00_axis_tdata           = s_axis_tdata[32*grant_idx +: 32];
      m00_axis_tkeep           = s_axis_tkeep[4*grant_idx +: 4];
      m00_axis_tvalid          = g_valid;
      m00_axis_tlast           = g_last;
      s_axis_tready[grant_idx] = m00_axis_tready;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant_idx   <= '0;
      last_grant  <= GW'(N_PORTS - 1);
      frame_count <= '0;
      abort_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|s_axis_tvalid) begin
            grant_idx <= winner;
            state     <= LOCKED;
          end
        end
        LOCKED: begin
          // A valid gap inside a frame is an abort, even while the MAC stalls.
          if (!g_valid) begin
            if (abort_count != '1) abort_count <= abort_count + 1'b1;
            last_grant <= grant_idx;
            state      <= IDLE;
          end else if (m00_axis_tready && g_last) begin
            if (frame_count != '1) frame_count <= frame_count + 1'b1;
            last_grant <= grant_idx;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_axis_arbiter.sv
// Self-checking bench for tx_axis_arbiter: directed scenarios with random data,
// checked against a transaction-level round-robin model.
module tb_tx_axis_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] s_tdata;
  logic [15:0]  s_tkeep;
  logic [3:0]   s_tvalid;
  logic [3:0]   s_tlast;
  logic [3:0]   s_tready;
  logic [31:0]  m_tdata;
  logic [3:0]   m_tkeep;
  logic         m_tvalid;
  logic         m_tlast;
  logic         m_ready;
  logic [1:0]   grant_idx;
  logic         busy;
  logic [3:0]   frame_count;
  logic [3:0]   abort_count;

  int checks = 0;
  int errors = 0;

  // Model state: busy flag, granted port, previous winner, saturating counters
  bit m_busy;
  int m_grant, m_last, m_frames, m_aborts;

  always #5 clk = ~clk;

  tx_axis_arbiter #(.N_PORTS(4), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m00_axis_tdata(m_tdata), .m00_axis_tkeep(m_tkeep), .m00_axis_tvalid(m_tvalid),
    .m00_axis_tlast(m_tlast), .m00_axis_tready(m_ready),
    .grant_idx(grant_idx), .busy(busy),
    .frame_count(frame_count), .abort_count(abort_count)
  );

  // Valid port nearest after 'last' in circular order
  function automatic int rr_pick(int last, logic [3:0] v);
    int best  = -1;
    int bestd = 4;
    for (int p = 0; p < 4; p++) begin
      if (v[p]) begin
        int d;
        d = (p - last - 1 + 4) % 4;
        if (d < bestd) begin bestd = d; best = p; end
      end
    end
    return best;
  endfunction

  task automatic rand_data();
    s_tdata = {$urandom, $urandom, $urandom, $urandom};
    s_tkeep = 16'($urandom);
  endtask

  // Advance the model on the current inputs, then the clock edge, then settle
  task automatic tick();
    if (reset) begin
      m_busy = 0; m_grant = 0; m_last = 3; m_frames = 0; m_aborts = 0;
    end else if (!m_busy) begin
      if (s_tvalid != 4'b0) begin m_grant = rr_pick(m_last, s_tvalid); m_busy = 1; end
    end else if (!s_tvalid[m_grant]) begin
      if (m_aborts < 15) m_aborts++;
      m_last = m_grant; m_busy = 0;
    end else if (m_ready && s_tlast[m_grant]) begin
      if (m_frames < 15) m_frames++;
      m_last = m_grant; m_busy = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1; s_tvalid = 4'hf; s_tlast = 4'hf; m_ready = 1; rand_data();
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", busy); end
    checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL rst_grant: got %0d expected 0", grant_idx); end
    checks++; if ({frame_count, abort_count} !== 8'h00) begin errors++; $display("FAIL rst_counts: got %0h/%0h expected 0/0", frame_count, abort_count); end
    checks++; if (s_tready !== 4'h0) begin errors++; $display("FAIL rst_tready: got %0h expected 0", s_tready); end
    checks++; if ({m_tdata, m_tkeep, m_tvalid, m_tlast} !== 38'h0) begin errors++; $display("FAIL rst_m00: got %0h/%0h/%0b/%0b expected all 0", m_tdata, m_tkeep, m_tvalid, m_tlast); end
    reset = 0; s_tvalid = 4'h0; s_tlast = 4'h0;
    tick();
  endtask

  task automatic test_single_port();
    logic [31:0] beats[16];
    for (int i = 0; i < 16; i++) beats[i] = $urandom;
    rand_data(); s_tdata[64 +: 32] = beats[0]; s_tvalid = 4'b0100; s_tlast = 4'h0; m_ready = 1;
    #1;
    checks++; if ({busy, m_tvalid} !== 2'b00) begin errors++; $display("FAIL sp_idle: got busy=%0b valid=%0b expected 0/0", busy, m_tvalid); end
    tick();
    checks++; if (grant_idx !== 2'd2 || busy !== 1'b1) begin errors++; $display("FAIL sp_grant: got %0d busy=%0b expected 2 busy=1", grant_idx, busy); end
    for (int b = 0; b < 16; b++) begin
      rand_data(); s_tdata[64 +: 32] = beats[b];
      s_tlast = 4'($urandom) & 4'b1011;
      if (b == 15) s_tlast[2] = 1'b1;
      #1;
      checks++;
      if (m_tdata !== beats[b] || m_tkeep !== s_tkeep[8 +: 4] || m_tvalid !== 1'b1 ||
          m_tlast !== (b == 15) || s_tready !== 4'b0100) begin
        errors++;
        $display("FAIL sp_beat%0d: got data=%0h keep=%0h v=%0b l=%0b rdy=%0h expected data=%0h keep=%0h v=1 l=%0b rdy=4",
                 b, m_tdata, m_tkeep, m_tvalid, m_tlast, s_tready, beats[b], s_tkeep[8 +: 4], (b == 15));
      end
      tick();
    end
    s_tvalid = 4'h0; s_tlast = 4'h0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sp_done: got busy=%0b expected 0", busy); end
    checks++; if (frame_count !== 4'd1 || int'(frame_count) != m_frames) begin errors++; $display("FAIL sp_frames: got %0d expected 1", frame_count); end
    checks++; if (grant_idx !== 2'd2) begin errors++; $display("FAIL sp_hold: got %0d expected 2", grant_idx); end
  endtask

  task automatic test_round_robin();
    int beat[4];
    int frm[4];
    int grants[$];
    int idle_between = 0;
    int done = 0;
    int cyc = 0;
    bit prev_busy = 0;
    bit seen_first = 0;
    reset = 1; tick(); reset = 0;
    for (int p = 0; p < 4; p++) begin beat[p] = 0; frm[p] = 0; end
    s_tvalid = 4'hf; m_ready = 1;
    while (done < 8 && cyc < 200) begin
      for (int p = 0; p < 4; p++) begin
        s_tdata[32*p +: 32] = {8'(p), 16'(frm[p]), 8'(beat[p])};
        s_tlast[p] = (beat[p] == 2);
      end
      #1;
      checks++; if (busy !== m_busy) begin errors++; $display("FAIL rr_busy cyc%0d: got %0b expected %0b", cyc, busy, m_busy); end
      if (m_busy) begin
        if (!prev_busy) grants.push_back(int'(grant_idx));
        seen_first = 1;
        checks++;
        if (int'(grant_idx) != m_grant || m_tdata !== {8'(m_grant), 16'(frm[m_grant]), 8'(beat[m_grant])}) begin
          errors++;
          $display("FAIL rr_beat cyc%0d: got grant=%0d data=%0h expected grant=%0d data=%0h",
                   cyc, grant_idx, m_tdata, m_grant, {8'(m_grant), 16'(frm[m_grant]), 8'(beat[m_grant])});
        end
        if (beat[m_grant] == 2) begin beat[m_grant] = 0; frm[m_grant]++; done++; end
        else beat[m_grant]++;
      end else if (seen_first) begin
        idle_between++;
      end
      prev_busy = m_busy;
      tick(); cyc++;
    end
    checks++; if (cyc >= 200) begin errors++; $display("FAIL rr_timeout: got %0d frames expected 8", done); end
    checks++; if (grants.size() != 8) begin errors++; $display("FAIL rr_count: got %0d grants expected 8", grants.size()); end
    for (int i = 0; i < 8 && i < grants.size(); i++) begin
      checks++; if (grants[i] != i % 4) begin errors++; $display("FAIL rr_order%0d: got %0d expected %0d", i, grants[i], i % 4); end
    end
    checks++; if (idle_between != 7) begin errors++; $display("FAIL rr_bubbles: got %0d expected 7", idle_between); end
    checks++; if (frame_count !== 4'd8) begin errors++; $display("FAIL rr_frames: got %0d expected 8", frame_count); end
    s_tvalid = 4'h0; s_tlast = 4'h0; tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] beats[6];
    int b = 0;
    int cyc = 0;
    int f0;
    f0 = m_frames;
    for (int i = 0; i < 6; i++) beats[i] = $urandom;
    s_tvalid = 4'b0010; s_tlast = 4'h0; rand_data(); tick();
    s_tvalid = 4'b0011;
    while (b < 6 && cyc < 40) begin
      rand_data(); s_tdata[32 +: 32] = beats[b];
      s_tlast = 4'($urandom); s_tlast[1] = (b == 5);
      m_ready = (cyc % 3 == 0);
      #1;
      checks++; if (grant_idx !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL bp_grant cyc%0d: got %0d busy=%0b expected 1 busy=1", cyc, grant_idx, busy); end
      checks++; if (s_tready !== {2'b00, m_ready, 1'b0}) begin errors++; $display("FAIL bp_tready cyc%0d: got %0h expected %0h", cyc, s_tready, {2'b00, m_ready, 1'b0}); end
      if (m_ready) begin
        checks++; if (m_tdata !== beats[b]) begin errors++; $display("FAIL bp_data%0d: got %0h expected %0h", b, m_tdata, beats[b]); end
        b++;
      end
      tick(); cyc++;
    end
    checks++; if (cyc >= 40) begin errors++; $display("FAIL bp_timeout: got %0d beats expected 6", b); end
    s_tvalid = 4'h0; s_tlast = 4'h0; m_ready = 1; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_done: got busy=%0b expected 0", busy); end
    checks++; if (int'(frame_count) != f0 + 1) begin errors++; $display("FAIL bp_frames: got %0d expected %0d", frame_count, f0 + 1); end
  endtask

  task automatic test_abort();
    int a0, f0;
    a0 = m_aborts; f0 = m_frames;
    s_tvalid = 4'b1000; s_tlast = 4'h0; m_ready = 1; rand_data(); tick();
    for (int b = 0; b < 5; b++) begin
      rand_data(); #1;
      checks++; if (grant_idx !== 2'd3 || m_tdata !== s_tdata[96 +: 32]) begin errors++; $display("FAIL ab_beat%0d: got grant=%0d data=%0h expected grant=3 data=%0h", b, grant_idx, m_tdata, s_tdata[96 +: 32]); end
      tick();
    end
    s_tvalid = 4'h0; m_ready = 0; #1;
    checks++; if (busy !== 1'b1 || m_tvalid !== 1'b0) begin errors++; $display("FAIL ab_gap: got busy=%0b valid=%0b expected 1/0", busy, m_tvalid); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ab_idle: got busy=%0b expected 0", busy); end
    checks++; if (int'(abort_count) != a0 + 1 || int'(frame_count) != f0) begin errors++; $display("FAIL ab_counts: got abort=%0d frame=%0d expected %0d/%0d", abort_count, frame_count, a0 + 1, f0); end
    s_tvalid = 4'hf; m_ready = 1; tick();
    checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL ab_next: got %0d expected 0", grant_idx); end
    s_tlast = 4'b0001; tick();
    s_tvalid = 4'h0; s_tlast = 4'h0; tick();
  endtask

  task automatic test_reset_mid_frame();
    s_tvalid = 4'b0001; s_tlast = 4'h0; m_ready = 1; rand_data(); tick();
    for (int b = 0; b < 3; b++) begin rand_data(); tick(); end
    reset = 1; tick();
    checks++; if (busy !== 1'b0 || s_tready !== 4'h0 || m_tvalid !== 1'b0) begin errors++; $display("FAIL rm_release: got busy=%0b rdy=%0h valid=%0b expected 0/0/0", busy, s_tready, m_tvalid); end
    checks++; if ({frame_count, abort_count} !== 8'h00) begin errors++; $display("FAIL rm_counts: got %0d/%0d expected 0/0", frame_count, abort_count); end
    reset = 0; s_tvalid = 4'b0011; tick();
    checks++; if (grant_idx !== 2'd0 || busy !== 1'b1) begin errors++; $display("FAIL rm_first: got %0d busy=%0b expected 0 busy=1", grant_idx, busy); end
    s_tlast = 4'b0001; tick();
    s_tvalid = 4'h0; s_tlast = 4'h0; tick();
  endtask

  task automatic test_saturation();
    for (int f = 0; f < 20; f++) begin
      s_tvalid = 4'($urandom_range(1, 15)); s_tlast = 4'hf; m_ready = 1; rand_data();
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sat_idle%0d: got busy=%0b expected 0", f, busy); end
      tick();
      checks++;
      if (busy !== 1'b1 || int'(grant_idx) != m_grant || m_tdata !== s_tdata[32*m_grant +: 32]) begin
        errors++;
        $display("FAIL sat_grant%0d: got busy=%0b grant=%0d data=%0h expected busy=1 grant=%0d data=%0h",
                 f, busy, grant_idx, m_tdata, m_grant, s_tdata[32*m_grant +: 32]);
      end
      tick();
    end
    s_tvalid = 4'h0; s_tlast = 4'h0; #1;
    checks++; if (frame_count !== 4'd15 || int'(frame_count) != m_frames) begin errors++; $display("FAIL sat_frames: got %0d expected 15", frame_count); end
  endtask

  initial begin
    reset = 1; s_tdata = '0; s_tkeep = '0; s_tvalid = '0; s_tlast = '0; m_ready = 0;
    m_busy = 0; m_grant = 0; m_last = 3; m_frames = 0; m_aborts = 0;
    test_reset();
    test_single_port();
    test_round_robin();
    test_backpressure();
    test_abort();
    test_reset_mid_frame();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tx_axis_arbiter.md
TX_AXIS_ARBITER -- requirements
Module: tx_axis_arbiter

Interface
REQ-001 Parameter: N_PORTS, default 4, number of AXIS requester ports; legal range 2..8.
REQ-002 Parameter: CNT_WIDTH, default 16, width of the frame and abort counters.
REQ-003 Ports (clock and reset first):
- clk  in  1  sole clock; every port is synchronous to it.
- reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  N_PORTS*32  requester data; port i occupies bits [32*i +: 32].
- s_axis_tkeep  in  N_PORTS*4  requester byte enables; port i occupies bits [4*i +: 4].
- s_axis_tvalid  in  N_PORTS  requester valid, one bit per port.
- s_axis_tlast  in  N_PORTS  requester end of frame, one bit per port.
- s_axis_tready  out  N_PORTS  per-port ready.
- m00_axis_tdata  out  32  data to the MAC transmit input.
- m00_axis_tkeep  out  4  byte enables to the MAC.
- m00_axis_tvalid  out  1  valid to the MAC.
- m00_axis_tlast  out  1  end of frame to the MAC.
- m00_axis_tready  in  1  ready from the MAC.
- grant_idx  out  clog2(N_PORTS)  index of the port currently granted.
- busy  out  1  high while in LOCKED.
- frame_count  out  CNT_WIDTH  number of frames completed.
- abort_count  out  CNT_WIDTH  number of frames aborted.

Function
REQ-004 The block SHALL implement a two-state FSM with states IDLE and LOCKED; reset places it in IDLE.
REQ-005 In IDLE, m00_axis_tvalid and every bit of s_axis_tready SHALL be 0, and m00_axis_tdata, m00_axis_tkeep and m00_axis_tlast SHALL be 0.
REQ-006 In IDLE, when any s_axis_tvalid bit is 1, the block SHALL select a port round-robin:
- the search starts at (last_grant+1) mod N_PORTS and proceeds upward with wrap;
- the first port with tvalid=1 wins;
- the winner is registered into grant_idx;
- the FSM enters LOCKED on the next edge (arbitration latency: 1 cycle).
REQ-007 In LOCKED, m00_axis_tdata, tkeep, tvalid and tlast SHALL combinationally equal the granted port's inputs.
REQ-008 In LOCKED, s_axis_tready[grant_idx] SHALL equal m00_axis_tready combinationally; all other s_axis_tready bits SHALL be 0.
REQ-009 A beat SHALL transfer only when m00_axis_tvalid and m00_axis_tready are both 1; no beat is duplicated, dropped or reordered.
REQ-010 Frame completion: on a transfer with tlast=1 in LOCKED, the block SHALL:
- load last_grant with grant_idx;
- increment frame_count;
- return to IDLE on the next edge.
REQ-011 A new grant SHALL NOT take effect before one IDLE cycle has elapsed, so back-to-back frames incur exactly one bubble cycle.
REQ-012 Abort: if the granted port's tvalid is 0 in any LOCKED cycle, the block SHALL:
- increment abort_count;
- load last_grant with grant_idx;
- return to IDLE on the next edge.
The MAC requires tvalid to stay high for the whole frame.
REQ-013 The grant SHALL be held for the whole frame regardless of tvalid on other ports, and regardless of m00_axis_tready being low for any number of cycles.
REQ-014 The tvalid=0 abort check of REQ-012 applies regardless of m00_axis_tready.
REQ-015 frame_count and abort_count SHALL saturate at all-ones and never wrap.
REQ-016 busy SHALL be 1 in LOCKED and 0 in IDLE.
REQ-017 grant_idx SHALL hold its value through IDLE until the next arbitration.
REQ-018 Non-granted ports' tdata, tkeep and tlast SHALL have no effect on any output.

Reset
REQ-019 While reset is 1 at a clock edge, the following SHALL be set on that edge:
- FSM = IDLE;
- grant_idx = 0;
- last_grant = N_PORTS-1, so port 0 has first priority;
- frame_count = 0 and abort_count = 0.
REQ-020 Reset asserted mid-frame SHALL release the grant within that cycle's edge and drive all s_axis_tready bits and m00_axis_tvalid to 0 from the following cycle; no counter increments for the truncated frame.
REQ-021 All outputs SHALL be deterministic (no X) from the first edge with reset=1.

Verification
REQ-022 Single port, 16-beat frame on port 2, m00 tready=1:
- response: grant_idx=2 one cycle after tvalid rises;
- all 16 beats pass in order;
- frame_count=1;
- return to IDLE after the tlast beat.
REQ-023 All 4 ports valid continuously with 3-beat frames, N_PORTS=4:
- response: grant order 0,1,2,3,0,...;
- exactly one bubble cycle between frames;
- frame_count=8 after 8 frames.
REQ-024 Backpressure: m00 tready toggles 1,0,0,1,... during a port-1 frame while port 0 is also valid:
- response: the grant stays on 1 until tlast;
- non-granted tready stays 0 throughout;
- data matches the sent sequence.
REQ-025 Port 3 drops tvalid at beat 5 of 10:
- response: abort_count=1 and frame_count unchanged;
- FSM in IDLE the next cycle;
- the next arbitration starts its search at port 0.
REQ-026 Reset asserted at beat 3 of a port-0 frame:
- response: the next cycle has busy=0 and all tready=0;
- counters=0;
- after reset, port 0 wins first when ports 0 and 1 are both valid.
REQ-027 Counter saturation with CNT_WIDTH=4: send 20 frames -> frame_count holds at 15.
